// File: rtl/seg_i2c_driver_n.sv
// Multi-digit 7-segment display driver: on a strobe it snapshots the digit bytes
// and writes them to the display controller as one I2C frame (addr, reg, data).
module seg_i2c_driver_n #(
    parameter int         NUM_DIGITS     = 4,
    parameter int         CLK_DIV        = 1024,
    parameter logic [6:0] DEV_ADDR       = 7'h70,
    parameter logic [7:0] REG_BASE       = 8'h00,
    parameter int         REFRESH_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sync_reset_i,
    input  logic [8*NUM_DIGITS-1:0] digits_i,
    input  logic                    disp_strobe_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    nack_o,
    output logic                    sda_out,
    input  logic                    sda_in,
    output logic                    sda_out_en,
    output logic                    seg_scl_o,
    output logic [2:0]              dbg_state_o
);

    // disp_strobe_i is a 1-cycle request with no ready: a strobe in IDLE starts a
    // frame at once, strobes while busy collapse into a single pending request.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_REG   = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam int QW = $clog2(CLK_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    state_t                  state_q, state_d;
    logic [QW-1:0]           q_cnt_q;
    logic [1:0]              qtr_q;
    logic [3:0]              bit_q;
    logic [DW-1:0]           idx_q;
    logic [8*NUM_DIGITS-1:0] digits_q;
    logic                    pend_q;
    logic                    nack_seen_q;
    logic [RW-1:0]           refresh_q;
    logic                    done_q;
    logic                    nack_q;

    logic       tick;
    logic       slot_end;
    logic       ack_sample;
    logic       ack_slot_end;
    logic       refresh_hit;
    logic       start_req;
    logic       frame_start;
    logic       last_digit;
    logic [7:0] cur_byte;
    logic [2:0] bit_sel;

    assign tick         = (q_cnt_q == QW'(CLK_DIV - 1));
    assign slot_end     = tick && (qtr_q == 2'd3);
    assign ack_sample   = tick && (qtr_q == 2'd2) && (bit_q == 4'd8);
    assign ack_slot_end = slot_end && (bit_q == 4'd8);
    assign refresh_hit  = (REFRESH_CYCLES > 0) && (state_q == S_IDLE) &&
                          (refresh_q == RW'(REFRESH_CYCLES - 1));
    assign start_req    = disp_strobe_i || pend_q || refresh_hit;
    assign frame_start  = (state_q == S_IDLE) && start_req;
    assign last_digit   = (idx_q == DW'(NUM_DIGITS - 1));
    assign bit_sel      = 3'd7 - bit_q[2:0];

    always_comb begin
        cur_byte = digits_q[{idx_q, 3'b000} +: 8];
        case (state_q)
            S_ADDR:  cur_byte = {DEV_ADDR, 1'b0};
            S_REG:   cur_byte = REG_BASE;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_START;
            S_START: if (slot_end) state_d = S_ADDR;
            S_ADDR:  if (ack_slot_end) state_d = nack_seen_q ? S_STOP : S_REG;
            S_REG:   if (ack_slot_end) state_d = nack_seen_q ? S_STOP : S_DATA;
            S_DATA:  if (ack_slot_end && (nack_seen_q || last_digit)) state_d = S_STOP;
            S_STOP:  if (slot_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus pins decode straight from registered state, so both resets force them.
    always_comb begin
        seg_scl_o  = 1'b1;
        sda_out_en = 1'b0;
        case (state_q)
            S_START: sda_out_en = qtr_q[1];
            S_ADDR, S_REG, S_DATA: begin
                seg_scl_o  = qtr_q[1];
                sda_out_en = (bit_q != 4'd8) && !cur_byte[bit_sel];
            end
            S_STOP: begin
                seg_scl_o  = (qtr_q != 2'd0);
                sda_out_en = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign nack_o      = nack_q;
    assign sda_out     = 1'b0;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else if (sync_reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_cnt_q     <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            digits_q    <= '0;
            pend_q      <= 1'b0;
            nack_seen_q <= 1'b0;
            refresh_q   <= '0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else if (sync_reset_i) begin
            q_cnt_q     <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            digits_q    <= '0;
            pend_q      <= 1'b0;
            nack_seen_q <= 1'b0;
            refresh_q   <= '0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            done_q <= (state_q == S_STOP) && slot_end && !nack_seen_q;
            nack_q <= (state_q == S_STOP) && slot_end && nack_seen_q;

            if (state_q == S_IDLE) begin
                q_cnt_q <= '0;
                qtr_q   <= '0;
                bit_q   <= '0;
            end else begin
                if (tick) begin
                    q_cnt_q <= '0;
                    qtr_q   <= qtr_q + 2'd1;
                end else begin
                    q_cnt_q <= q_cnt_q + QW'(1);
                end
                if (slot_end) begin
                    bit_q <= ((state_q == S_START) || (bit_q == 4'd8)) ? 4'd0 : bit_q + 4'd1;
                end
            end

            if (frame_start) begin
                idx_q       <= '0;
                digits_q    <= digits_i;
                nack_seen_q <= 1'b0;
            end else begin
                if ((state_q == S_DATA) && ack_slot_end && !last_digit) begin
                    idx_q <= idx_q + DW'(1);
                end
                if (ack_sample && sda_in) begin
                    nack_seen_q <= 1'b1;
                end
            end

            if (frame_start) begin
                pend_q <= 1'b0;
            end else if ((state_q != S_IDLE) && disp_strobe_i) begin
                pend_q <= 1'b1;
            end

            // Refresh interval counts idle time only; it sits at zero during a frame.
            if (frame_start) begin
                refresh_q <= '0;
            end else if (state_q == S_IDLE) begin
                refresh_q <= refresh_q + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_i2c_driver_n.sv
// Bench for seg_i2c_driver_n: I2C slave/bus decoder feeding a byte and frame
// scoreboard, plus a second auto-refresh instance checked for interval timing.
module tb_seg_i2c_driver_n;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        srst;
    logic [31:0] digits;
    logic        strobe;
    logic        busy_a, done_a, nack_a, sda_out_a, sda_in_a, sda_en_a, scl_a;
    logic [2:0]  st_a;

    logic [7:0]  digits_b;
    logic        strobe_b;
    logic        busy_b, done_b, nack_b, sda_out_b, sda_en_b, scl_b;
    logic        sda_in_b;
    logic [2:0]  st_b;

    seg_i2c_driver_n #(.NUM_DIGITS(4), .CLK_DIV(4), .DEV_ADDR(7'h70),
                       .REG_BASE(8'h00), .REFRESH_CYCLES(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .sync_reset_i(srst), .digits_i(digits),
        .disp_strobe_i(strobe), .busy_o(busy_a), .done_o(done_a), .nack_o(nack_a),
        .sda_out(sda_out_a), .sda_in(sda_in_a), .sda_out_en(sda_en_a),
        .seg_scl_o(scl_a), .dbg_state_o(st_a)
    );

    seg_i2c_driver_n #(.NUM_DIGITS(1), .CLK_DIV(2), .DEV_ADDR(7'h70),
                       .REG_BASE(8'h00), .REFRESH_CYCLES(2000)) dut_b (
        .clk_i(clk), .rst_i(rst), .sync_reset_i(srst), .digits_i(digits_b),
        .disp_strobe_i(strobe_b), .busy_o(busy_b), .done_o(done_b), .nack_o(nack_b),
        .sda_out(sda_out_b), .sda_in(sda_in_b), .sda_out_en(sda_en_b),
        .seg_scl_o(scl_b), .dbg_state_o(st_b)
    );

    assign sda_in_b = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard queues: bytes on the bus, frame end kind (2=done, 1=nack), frame length
    logic [7:0]  exp_q[$];
    logic [31:0] kind_q[$];
    logic [31:0] len_q[$];

    // slave model + bus monitor
    logic       slave_pull = 1'b0;
    logic       sda_line;
    int         nack_at = -1;
    int         bitcnt = 0;
    int         byte_idx = 0;
    int         stop_cnt = 0;
    int         flen = 0;
    logic [7:0] shreg = 8'h00;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_busy = 1'b0;

    assign sda_line = !sda_en_a && !slave_pull;
    assign sda_in_a = sda_line;

    always @(negedge clk) begin
        if (rst || srst) begin
            bitcnt     = 0;
            byte_idx   = 0;
            slave_pull = 1'b0;
            flen       = 0;
        end else begin
            if (prev_scl && scl_a && prev_sda && !sda_line) begin
                bitcnt   = 0;
                byte_idx = 0;
            end else if (prev_scl && scl_a && !prev_sda && sda_line) begin
                bitcnt = 0;
                stop_cnt++;
            end else if (!prev_scl && scl_a) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], sda_line};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL byte_unexpected: got %0h expected none", shreg);
                        end else begin
                            check("byte", {24'd0, shreg}, {24'd0, exp_q.pop_front()});
                        end
                    end
                end else if (bitcnt == 8) begin
                    bitcnt = 9;
                end
            end else if (prev_scl && !scl_a) begin
                if (bitcnt == 8) begin
                    slave_pull = (byte_idx != nack_at);
                    byte_idx++;
                end else if (bitcnt == 9) begin
                    slave_pull = 1'b0;
                    bitcnt     = 0;
                end
            end

            if (busy_a && !prev_busy) flen = 0;
            else flen++;

            if (done_a || nack_a) begin
                if (kind_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_end_unexpected: got done=%0b nack=%0b expected none", done_a, nack_a);
                end else begin
                    check("frame_kind", 32'({done_a, nack_a}), kind_q.pop_front());
                    check("frame_len", 32'(flen), len_q.pop_front());
                    check("busy_at_end", 32'(busy_a), 32'd0);
                end
            end
        end
        prev_scl  = scl_a;
        prev_sda  = sda_line;
        prev_busy = busy_a;
    end

    // driver tasks
    task automatic push_frame(input logic [31:0] d);
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'h00);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(d[8*k +: 8]);
        end
        kind_q.push_back(32'd2);
        len_q.push_back(32'd896);
    endtask

    task automatic strobe_a();
        @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || kind_q.size() != 0 || busy_a) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < max), 32'd1);
    endtask

    task automatic flush();
        exp_q.delete();
        kind_q.delete();
        len_q.delete();
    endtask

    task automatic gap_b(input int strobe_at, output int g);
        g = 0;
        while (!busy_b && g < 5000) begin
            strobe_b = (g == strobe_at);
            g++;
            @(negedge clk);
        end
        strobe_b = 1'b0;
    endtask

    task automatic len_b(output int l);
        l = 0;
        while (!done_b && l < 5000) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int n;
        int s;
        rst      = 1'b1;
        srst     = 1'b0;
        strobe   = 1'b0;
        strobe_b = 1'b0;
        digits   = 32'h0;
        digits_b = 8'h3F;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_nack", 32'(nack_a), 32'd0);
        check("rst_sda_en", 32'(sda_en_a), 32'd0);
        check("rst_scl", 32'(scl_a), 32'd1);
        check("rst_sda_out", 32'(sda_out_a), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        check("rst_b_scl", 32'(scl_b), 32'd1);

        // basic frame
        digits = {8'h3F, 8'h06, 8'h5B, 8'h4F};
        push_frame(digits);
        strobe_a();
        wait_idle(2000);

        // snapshot: digits change mid-frame
        digits = 32'h11223344;
        push_frame(digits);
        strobe_a();
        repeat (300) @(negedge clk);
        digits = 32'hFFFFFFFF;
        wait_idle(2000);

        // three strobes while busy merge into one pending frame
        digits = 32'h01020304;
        push_frame(digits);
        strobe_a();
        repeat (100) @(negedge clk);
        strobe_a();
        digits = 32'hA0B0C0D0;
        push_frame(digits);
        repeat (100) @(negedge clk);
        strobe_a();
        repeat (100) @(negedge clk);
        strobe_a();
        n = 0;
        while (!done_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("pend_done_seen", 32'(done_a), 32'd1);
        g = 0;
        while (!busy_a && g < 10) begin
            g++;
            @(negedge clk);
        end
        check("pend_gap", 32'(g), 32'd1);
        wait_idle(2000);
        repeat (50) @(negedge clk);
        check("no_third_frame", 32'(busy_a), 32'd0);

        // NACK on the REG byte
        nack_at = 1;
        digits  = 32'hDEADBEEF;
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'h00);
        kind_q.push_back(32'd1);
        len_q.push_back(32'd320);
        s = stop_cnt;
        strobe_a();
        wait_idle(2000);
        check("nack_stop", 32'(stop_cnt), 32'(s + 1));
        nack_at = -1;

        // async reset in the middle of the first data byte (SCL low there)
        digits = 32'h55AA55AA;
        push_frame(digits);
        strobe_a();
        repeat (357) @(negedge clk);
        check("pre_rst_scl", 32'(scl_a), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_scl", 32'(scl_a), 32'd1);
        check("arst_sda_en", 32'(sda_en_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        flush();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        digits = 32'h12345678;
        push_frame(digits);
        strobe_a();
        wait_idle(2000);

        // sync reset at the same point: takes effect on the next edge
        digits = 32'h9ABCDEF0;
        push_frame(digits);
        strobe_a();
        repeat (357) @(negedge clk);
        srst = 1'b1;
        #1;
        check("srst_busy_held", 32'(busy_a), 32'd1);
        check("srst_scl_held", 32'(scl_a), 32'd0);
        flush();
        @(negedge clk);
        check("srst_scl", 32'(scl_a), 32'd1);
        check("srst_sda_en", 32'(sda_en_a), 32'd0);
        check("srst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        digits = 32'h0F1E2D3C;
        push_frame(digits);
        strobe_a();
        wait_idle(2000);

        // auto-refresh instance: 2000 idle cycles between frames, 232-cycle frames
        n = 0;
        while (!done_b && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("refresh_first_done", 32'(done_b), 32'd1);
        gap_b(-1, g);
        check("refresh_gap", 32'(g), 32'd2000);
        len_b(n);
        check("refresh_len", 32'(n), 32'd232);
        gap_b(1999, g);
        check("coincident_gap", 32'(g), 32'd2000);
        len_b(n);
        check("coincident_len", 32'(n), 32'd232);
        gap_b(-1, g);
        check("after_coincident_gap", 32'(g), 32'd2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_i2c_driver_n.md
# seg_i2c_driver_n

Parametrised multi-digit 7-segment display driver with an integrated I2C write engine. On a display strobe it snapshots `NUM_DIGITS` segment bytes and sends one I2C write frame (address, start register, data bytes) to the display controller. It also supports a pending-strobe queue, ACK checking with abort, and optional periodic auto-refresh. It replaces the fixed 4-digit driver/wrapper pair in the 7-segment display path.

## Interface
- `NUM_DIGITS`, 4, digit bytes per frame (1..16)
- `CLK_DIV`, 1024, clk_i cycles per SCL quarter-period (>=2)
- `DEV_ADDR`, 7'h70, 7-bit I2C slave address
- `REG_BASE`, 8'h00, register/command byte sent after the address
- `REFRESH_CYCLES`, 0, auto-refresh interval in clk_i cycles; 0 = disabled

- `clk_i`  in  1  system clock, single clock domain
- `rst_i`  in  1  reset, asynchronous, active-high
- `sync_reset_i`  in  1  synchronous soft reset, active-high
- `digits_i`  in  8*NUM_DIGITS  digit k at [8k+7:8k]
- `disp_strobe_i`  in  1  request a frame, 1-cycle pulse
- `busy_o`  out  1  frame in progress
- `done_o`  out  1  1-cycle pulse: frame completed with all ACKs
- `nack_o`  out  1  1-cycle pulse: frame aborted on NACK
- `sda_out`  out  1  SDA drive value; constant 0 (open-drain)
- `sda_in`  in  1  sampled SDA line
- `sda_out_en`  out  1  1 = pull SDA low; 0 = release
- `seg_scl_o`  out  1  SCL, push-pull

## Operation
- Reset values (rst_i or sync_reset_i): busy_o=0, done_o=0, nack_o=0, sda_out_en=0, seg_scl_o=1, sda_out=0. Pending flag, refresh counter and FSM are all cleared. A reset mid-frame abandons the bus immediately, with no STOP.
- FSM states: IDLE -> START -> ADDR -> REG -> DATA -> STOP -> IDLE.
- Each byte is 9 bit slots: 8 data bits MSB first, then an ACK slot with SDA released.
- Byte order:
  - ADDR sends {DEV_ADDR,1'b0}.
  - REG sends REG_BASE.
  - DATA sends digit 0 first, through digit NUM_DIGITS-1.
- Digit snapshot: digits_i is captured into an internal register in the cycle a frame starts. Later changes to digits_i do not affect the frame in flight.
- Strobe in IDLE: the frame starts. busy_o rises the next cycle.
- Strobe while busy: sets the pending flag. Only one pending request is kept; extra strobes merge. The pending frame starts the cycle after the current frame returns to IDLE, with a fresh snapshot.
- ACK check: sda_in is sampled in each ACK slot.
  - sda_in=0 means ACK.
  - sda_in=1 means NACK: skip the remaining bytes, go to STOP, and pulse nack_o on the IDLE-return cycle instead of done_o. The pending flag is preserved.
- Auto-refresh (REFRESH_CYCLES>0):
  - The counter runs while IDLE and reloads on every frame start.
  - On reaching REFRESH_CYCLES-1 it acts as an internal strobe.
  - An external strobe on the same cycle is the same request; only one frame starts.

## Timing
- Quarter period Q = CLK_DIV cycles. One bit slot is 4Q:
  - Q0 and Q1: SCL low. SDA changes at the start of Q0.
  - Q2 and Q3: SCL high.
  - sda_in is sampled on the last cycle of Q2.
- START (one slot): SDA released and SCL high for 2Q, then SDA pulled low with SCL high for 2Q.
- STOP (one slot):
  - Q0: SCL low, SDA low.
  - Q1–Q2: SCL high, SDA low.
  - Q3: SCL high, SDA released.
- Frame length: (9*(2+NUM_DIGITS)+2)*4*CLK_DIV cycles from busy_o rising to done_o. For NUM_DIGITS=4 and CLK_DIV=4 this is 896 cycles.
- Aborted frame length: slots up to and including the NACKing ACK slot, plus the STOP slot.
- done_o/nack_o pulse in the same cycle busy_o falls. With a pending request, busy_o stays low for exactly one cycle before rising again.
- Data bit 1 is sent by releasing SDA (sda_out_en=0); data bit 0 by pulling low (sda_out_en=1).

## Test plan
- Reset, then NUM_DIGITS=4, CLK_DIV=4, digits {8'h3F,8'h06,8'h5B,8'h4F}, ACK model always 0, one strobe -> decoded bytes are 8'hE0, 8'h00, 8'h4F, 8'h5B, 8'h06, 8'h3F (digit 0 = low byte, sent first); done_o exactly 896 cycles after busy_o rises.
- Change digits_i mid-frame -> transmitted bytes equal the snapshot taken at frame start.
- Three strobes during a frame -> exactly one extra frame follows; busy_o low for exactly 1 cycle between frames.
- Slave NACKs the REG byte -> STOP is emitted right after that ACK slot, nack_o pulses once, done_o stays 0, no DATA bytes are sent.
- REFRESH_CYCLES=2000 with no strobes -> frames start every 2000 idle cycles; a coincident external strobe yields a single frame.
- Assert rst_i mid DATA byte -> all outputs take their reset values asynchronously (seg_scl_o=1, sda_out_en=0); the next strobe produces a clean full frame. Repeat with sync_reset_i, where outputs take reset values on the next clock edge.
